adc_sample_ctrl: RTL and testbench

Conversion scheduler for the serial ADC receiver (`adc_eq`). Generates a programmable-rate sample trigger, pulses the receiver's `inicio`, captures the 12-bit word on the receiver's `band` strobe, optionally averages 2^AVG_LOG2 conversions, and presents a registered sample with a one-cycle valid strobe. It sits between `adc_eq` and the downstream processing logic and shares `clk_adc`/`rst_adc` with the receiver.

---
 rtl/adc_sample_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_adc_sample_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sample_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : adc_sample_ctrl
//  Purpose  : Conversion scheduler for the serial ADC receiver (adc_eq).
//             Generates a programmable-rate trigger, pulses the receiver
//             start, captures the 12-bit word on the receiver done strobe,
//             optionally averages 2^AVG_LOG2 conversions and presents a
//             registered sample with a one-cycle valid strobe.
//  Build    : define ADC_AVG_EN to build the averaging accumulator; without
//             it every accepted conversion is presented directly.
//  Ports    : clk_adc, rst_adc (sync, active-high)   clock / reset
//             en, period[15:0], clr_err              scheduling control
//             inicio                                 receiver start pulse
//             band_i, data_i[11:0], garg_i[3:0]      receiver result
//             sample_o[11:0], valid_o                output sample + strobe
//             busy_o, err_o, ovr_o                   status (err/ovr sticky)
//  Revision : 1.0 - initial release
// ============================================================================
module adc_sample_ctrl #(
   parameter int AVG_LOG2 = 2,
   parameter int TMO_CYC  = 32
) (
   input  logic        clk_adc,
   input  logic        rst_adc,
   input  logic        en,
   input  logic [15:0] period,
   input  logic        clr_err,
   output logic        inicio,
   input  logic        band_i,
   input  logic [11:0] data_i,
   input  logic [3:0]  garg_i,
   output logic [11:0] sample_o,
   output logic        valid_o,
   output logic        busy_o,
   output logic        err_o,
   output logic        ovr_o
);

   localparam int TMO_W = $clog2(TMO_CYC + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_CONV  = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [15:0]        cnt;
   logic               pending;
   logic [TMO_W-1:0]   tmo;

   logic               tick;
   logic               start_conv;
   logic               got_band;
   logic               timeout;
   logic               idle_off;

   if (AVG_LOG2 < 0 || AVG_LOG2 > 4) begin : g_avg_range_bad
      $error("adc_sample_ctrl: AVG_LOG2 must be within 0..4");
   end

   assign tick       = en && (cnt == 16'd0);
   assign start_conv = (state == S_IDLE) && en && pending;
   assign got_band   = (state == S_CONV) && band_i;
   assign timeout    = (state == S_CONV) && !band_i &&
                       (tmo == TMO_W'(TMO_CYC - 1));
   assign idle_off   = (state == S_IDLE) && !en;

   // ------------------------------------------------------------------
   // Trigger generator. A tick arriving while the previous one is still
   // waiting is merged and flagged as an overrun.
   // ------------------------------------------------------------------
   always_ff @(posedge clk_adc) begin
      if (rst_adc) begin
         cnt     <= 16'd0;
         pending <= 1'b0;
      end else if (!en) begin
         cnt     <= 16'd0;
         pending <= 1'b0;
      end else begin
         if (cnt == 16'd0) begin
            // period 0 behaves as period 1
            cnt <= (period == 16'd0) ? 16'd0 : period - 16'd1;
         end else begin
            cnt <= cnt - 16'd1;
         end
         // a tick in the same cycle as the hand-off keeps the request alive
         if (tick) begin
            pending <= 1'b1;
         end else if (start_conv) begin
            pending <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk_adc) begin
      if (rst_adc) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      inicio    = 1'b0;
      busy_o    = 1'b1;
      case (state)
         S_IDLE: begin
            busy_o = 1'b0;
            if (start_conv) begin
               state_nxt = S_START;
            end
         end
         S_START: begin
            inicio    = 1'b1;
            state_nxt = S_CONV;
         end
         S_CONV: begin
            if (band_i || timeout) begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            busy_o    = 1'b0;
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Watchdog on the receiver: counts CONV cycles without a done strobe.
   always_ff @(posedge clk_adc) begin
      if (rst_adc) begin
         tmo <= '0;
      end else if (state == S_START) begin
         tmo <= '0;
      end else if (state == S_CONV) begin
         tmo <= tmo + TMO_W'(1);
      end
   end

   // ------------------------------------------------------------------
   // Sticky status flags; a set event beats a simultaneous clear.
   // ------------------------------------------------------------------
   always_ff @(posedge clk_adc) begin
      if (rst_adc) begin
         err_o <= 1'b0;
         ovr_o <= 1'b0;
      end else begin
         if ((got_band && (garg_i != 4'd0)) || timeout) begin
            err_o <= 1'b1;
         end else if (clr_err) begin
            err_o <= 1'b0;
         end
         if (tick && pending) begin
            ovr_o <= 1'b1;
         end else if (clr_err) begin
            ovr_o <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Sample path. data_i is only valid while band_i is high, so it is
   // consumed in that very cycle.
   // ------------------------------------------------------------------
`ifdef ADC_AVG_EN
   localparam int ACC_W = 12 + AVG_LOG2;
   localparam int N_W   = AVG_LOG2 + 1;

   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] acc_sum;
   logic [N_W-1:0]   n;
   logic [N_W-1:0]   n_inc;

   assign acc_sum = acc + ACC_W'(data_i);
   assign n_inc   = n + N_W'(1);

   always_ff @(posedge clk_adc) begin
      if (rst_adc) begin
         acc      <= '0;
         n        <= '0;
         sample_o <= 12'd0;
         valid_o  <= 1'b0;
      end else begin
         valid_o <= 1'b0;
         if (got_band) begin
            if (n_inc == N_W'(1 << AVG_LOG2)) begin
               sample_o <= 12'(acc_sum >> AVG_LOG2);
               valid_o  <= 1'b1;
               acc      <= '0;
               n        <= '0;
            end else begin
               acc <= acc_sum;
               n   <= n_inc;
            end
         end else if (timeout || idle_off) begin
            // partial averages are discarded
            acc <= '0;
            n   <= '0;
         end
      end
   end
`else
   logic unused_ok;
   assign unused_ok = idle_off;

   always_ff @(posedge clk_adc) begin
      if (rst_adc) begin
         sample_o <= 12'd0;
         valid_o  <= 1'b0;
      end else begin
         valid_o <= 1'b0;
         if (got_band) begin
            sample_o <= data_i;
            valid_o  <= 1'b1;
         end
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_adc_sample_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adc_sample_ctrl
//  Purpose  : Self-checking bench for adc_sample_ctrl with a behavioural
//             receiver model and a sum/divide averaging reference.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_adc_sample_ctrl;

   localparam int AVG = 2;
   localparam int TMO = 32;
`ifdef ADC_AVG_EN
   localparam int NAVG = 1 << AVG;
`else
   localparam int NAVG = 1;
`endif

   logic        clk_adc = 1'b0;
   logic        rst_adc, en, clr_err, inicio, band_i;
   logic        valid_o, busy_o, err_o, ovr_o;
   logic [15:0] period;
   logic [11:0] data_i, sample_o;
   logic [3:0]  garg_i;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // receiver model state
   int rx_cnt  = 0;
   bit rx_on   = 1'b1;
   int rx_data = 0;
   int rx_garg = 0;

   // reference model
   int m_sum  = 0;
   int m_n    = 0;
   int m_last = 0;
   bit m_err  = 1'b0;
   bit m_ovr  = 1'b0;

   adc_sample_ctrl #(.AVG_LOG2(AVG), .TMO_CYC(TMO)) dut (
      .clk_adc  (clk_adc),
      .rst_adc  (rst_adc),
      .en       (en),
      .period   (period),
      .clr_err  (clr_err),
      .inicio   (inicio),
      .band_i   (band_i),
      .data_i   (data_i),
      .garg_i   (garg_i),
      .sample_o (sample_o),
      .valid_o  (valid_o),
      .busy_o   (busy_o),
      .err_o    (err_o),
      .ovr_o    (ovr_o)
   );

   always #5 clk_adc = ~clk_adc;
   always @(posedge clk_adc) cyc <= cyc + 1;

   // Receiver: band 17 cycles after inicio (16 shifts plus load).
   initial begin
      band_i = 1'b0; data_i = 12'd0; garg_i = 4'd0;
      forever begin
         @(negedge clk_adc);
         band_i = 1'b0; data_i = 12'd0; garg_i = 4'd0;
         if (rst_adc === 1'b1) begin
            rx_cnt = 0;
         end else if (rx_cnt > 0) begin
            rx_cnt--;
            if (rx_cnt == 0) begin
               band_i = 1'b1;
               data_i = 12'(rx_data);
               garg_i = 4'(rx_garg);
            end
         end else if (inicio === 1'b1 && rx_on) begin
            rx_cnt = 17;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) @(negedge clk_adc);
   endtask

   task automatic model_clear();
      m_sum = 0;
      m_n   = 0;
   endtask

   task automatic model_accept(input int d, output bit v);
      m_sum += d;
      m_n++;
      v = 1'b0;
      if (m_n == NAVG) begin
         v      = 1'b1;
         m_last = m_sum / NAVG;
         model_clear();
      end
   endtask

   task automatic chk_reset_vals();
      chk("rst_inicio", {31'd0, inicio}, 0);
      chk("rst_valid",  {31'd0, valid_o}, 0);
      chk("rst_busy",   {31'd0, busy_o}, 0);
      chk("rst_err",    {31'd0, err_o}, 0);
      chk("rst_ovr",    {31'd0, ovr_o}, 0);
      chk("rst_sample", {20'd0, sample_o}, 0);
   endtask

   task automatic conv_start(input int d, input int g, input int exp_t, output int t);
      int k;
      rx_data = d;
      rx_garg = g;
      k = 0;
      while (inicio !== 1'b1 && k < 80) begin
         @(negedge clk_adc);
         k++;
      end
      t = cyc;
      chk("inicio_seen", {31'd0, inicio}, 1);
      chk("inicio_time", t, exp_t);
      @(negedge clk_adc);
      chk("inicio_pulse", {31'd0, inicio}, 0);
      chk("busy_conv", {31'd0, busy_o}, 1);
   endtask

   task automatic conv_finish(input int t);
      bit v;
      wait_until(t + 17);
      chk("valid_early", {31'd0, valid_o}, 0);
      chk("err_pre", {31'd0, err_o}, {31'd0, m_err});
      wait_until(t + 18);
      model_accept(rx_data, v);
      if (rx_garg != 0) m_err = 1'b1;
      chk("valid", {31'd0, valid_o}, {31'd0, v});
      chk("sample", {20'd0, sample_o}, m_last);
      chk("err", {31'd0, err_o}, {31'd0, m_err});
      chk("ovr", {31'd0, ovr_o}, {31'd0, m_ovr});
      chk("busy_idle", {31'd0, busy_o}, 0);
   endtask

   task automatic pulse_clr();
      clr_err = 1'b1;
      @(negedge clk_adc);
      clr_err = 1'b0;
      m_err = 1'b0;
      m_ovr = 1'b0;
      chk("clr_err", {31'd0, err_o}, 0);
   endtask

   initial begin
      int t;
      int t0;
      int k;
      int cnt_ini;
      int avg_vals[4];
      avg_vals = '{100, 200, 300, 401};

      rst_adc = 1'b1; en = 1'b0; clr_err = 1'b0; period = 16'd40;
      repeat (3) @(negedge clk_adc);
      chk_reset_vals();
      rst_adc = 1'b0;
      @(negedge clk_adc);

      // period 40: 0xABC then random words, then the 100/200/300/401 group
      en = 1'b1;
      t0 = cyc;
      k = 0;
      for (int i = 0; i < 8; i++) begin
         int d;
         if (i == 0)     d = 12'hABC;
         else if (i < 4) d = int'($urandom_range(0, 4095));
         else            d = avg_vals[i-4];
         conv_start(d, 0, t0 + 2 + 40 * k, t);
         conv_finish(t);
         k++;
      end

      // leading bits nonzero: sticky error, then cleared
      conv_start(int'($urandom_range(0, 4095)), 3, t0 + 2 + 40 * k, t);
      conv_finish(t);
      k++;
      repeat (3) @(negedge clk_adc);
      chk("err_hold", {31'd0, err_o}, 1);
      pulse_clr();

      // receiver silent: timeout after 32 CONV cycles
      rx_on = 1'b0;
      conv_start(0, 0, t0 + 2 + 40 * k, t);
      k++;
      wait_until(t + 18);
      chk("tmo_novalid", {31'd0, valid_o}, 0);
      wait_until(t + 32);
      chk("tmo_busy_last", {31'd0, busy_o}, 1);
      chk("tmo_err_pre", {31'd0, err_o}, 0);
      wait_until(t + 33);
      chk("tmo_idle", {31'd0, busy_o}, 0);
      chk("tmo_err", {31'd0, err_o}, 1);
      chk("tmo_valid", {31'd0, valid_o}, 0);
      model_clear();
      rx_on = 1'b1;
      pulse_clr();
      conv_start(int'($urandom_range(0, 4095)), 0, t0 + 2 + 40 * k, t);
      conv_finish(t);

      // period 5: overrun and back-to-back conversions every 19 cycles
      en = 1'b0;
      @(negedge clk_adc);
      model_clear();
      period = 16'd5;
      en = 1'b1;
      t0 = cyc;
      conv_start(int'($urandom_range(0, 4095)), 0, t0 + 2, t);
      wait_until(t0 + 10);
      chk("ovr_pre", {31'd0, ovr_o}, 0);
      wait_until(t0 + 11);
      chk("ovr_set", {31'd0, ovr_o}, 1);
      m_ovr = 1'b1;
      conv_finish(t);
      conv_start(int'($urandom_range(0, 4095)), 0, t0 + 21, t);
      conv_finish(t);
      // enable drops mid-conversion: it still completes
      conv_start(int'($urandom_range(0, 4095)), 0, t0 + 40, t);
      en = 1'b0;
      conv_finish(t);
      model_clear();
      cnt_ini = 0;
      repeat (25) begin
         @(negedge clk_adc);
         if (inicio === 1'b1) cnt_ini++;
      end
      chk("en_off_noinicio", cnt_ini, 0);
      chk("en_off_busy", {31'd0, busy_o}, 0);

      // reset in the middle of a conversion
      period = 16'd40;
      en = 1'b1;
      t0 = cyc;
      conv_start(int'($urandom_range(0, 4095)), 0, t0 + 2, t);
      wait_until(t0 + 10);
      rst_adc = 1'b1;
      @(negedge clk_adc);
      chk_reset_vals();
      m_err = 1'b0; m_ovr = 1'b0; m_last = 0;
      model_clear();
      repeat (2) @(negedge clk_adc);
      rst_adc = 1'b0;
      en = 1'b0;
      @(negedge clk_adc);
      en = 1'b1;
      t0 = cyc;
      conv_start(int'($urandom_range(0, 4095)), 0, t0 + 2, t);
      conv_finish(t);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
